// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: instruction field
// constants, ALU operation codes, datapath mux codes, FSM state encoding and
// the packed bundle of single-bit/mux control outputs.
package mips_ctrl_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnNor = 6'h27;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU operation select
  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXnor = 4'b0100;  // reserved, never generated
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;

  // ALU B operand select
  localparam logic [1:0] SrcBRt    = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  // PC source select
  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;

  typedef enum logic [3:0] {
    StFetch, StDecode, StRExec, StRWb, StIExec, StIWb, StMemAddr,
    StMemRd, StLwWb, StMemWr, StBranch, StJump, StIllegal
  } state_e;

  // How the ALU operation is chosen in a given state
  typedef enum logic [1:0] {AluClsAdd, AluClsSub, AluClsFunct, AluClsImm} alu_cls_e;

  typedef struct packed {
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       illegal;
    logic       mem_timeout;
  } ctrl_t;

  function automatic logic is_rtype_funct(logic [5:0] f);
    return f inside {FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt};
  endfunction

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU operation decoder.
//   alu_cls_i : selects fixed ADD/SUB, decode from funct, or decode from opcode
//   opcode_i  : IR[31:26], used for the immediate class
//   funct_i   : IR[5:0], used for the funct class
//   alu_op_o  : 4-bit ALU operation select
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_cls_e   alu_cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_op_o
);

  always_comb begin
    alu_op_o = AluAdd;
    unique case (alu_cls_i)
      AluClsAdd: alu_op_o = AluAdd;
      AluClsSub: alu_op_o = AluSub;
      AluClsFunct: begin
        case (funct_i)
          FnAdd:   alu_op_o = AluAdd;
          FnSub:   alu_op_o = AluSub;
          FnAnd:   alu_op_o = AluAnd;
          FnOr:    alu_op_o = AluOr;
          FnNor:   alu_op_o = AluNor;
          FnSlt:   alu_op_o = AluSlt;
          default: alu_op_o = AluAdd;
        endcase
      end
      AluClsImm: begin
        case (opcode_i)
          OpAddi:  alu_op_o = AluAdd;
          OpAndi:  alu_op_o = AluAnd;
          OpOri:   alu_op_o = AluOr;
          OpSlti:  alu_op_o = AluSlt;
          default: alu_op_o = AluAdd;
        endcase
      end
      default: alu_op_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM controller for the multicycle MIPS datapath.
// Inputs : clock, reset (sync, active-high), opcode/funct from IR, zero (ALU
//          flag, gated into the PC write by the datapath), mem_ready handshake.
// Outputs: ALU op and operand selects, PC/memory/IR/register-file controls,
//          illegal and mem_timeout pulses, retired and illegal_count counters.
module mips_multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [3:0]           alu_op,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic                 ext_zero,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic [1:0]           pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 illegal,
  output logic                 mem_timeout,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [CNT_WIDTH-1:0] illegal_count
);
  import mips_ctrl_pkg::*;

  localparam int unsigned WaitW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WaitW-1:0] TimeoutVal = WaitW'(TIMEOUT_CYCLES);

  state_e               state_q, state_d;
  logic [WaitW-1:0]     wait_q;
  logic [CNT_WIDTH-1:0] retired_q, illegal_q;
  ctrl_t                ctl, ctl_out;
  alu_cls_e             alu_cls;
  logic [3:0]           alu_op_raw;
  logic                 wait_state, timeout, retire;

  // The PC write is qualified by zero inside the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  assign wait_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // A ready arriving on the expiry cycle wins over the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && wait_state && !mem_ready && (wait_q == TimeoutVal);

  mips_alu_decoder u_alu_decoder (
    .alu_cls_i (alu_cls),
    .opcode_i  (opcode),
    .funct_i   (funct),
    .alu_op_o  (alu_op_raw)
  );

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    alu_cls = AluClsAdd;
    retire  = 1'b0;
    unique case (state_q)
      StFetch: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SrcBFour;
        ctl.pc_source = PcSrcAlu;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = StDecode;
        end else begin
          ctl.mem_timeout = timeout;
        end
      end
      StDecode: begin
        ctl.alu_src_b = SrcBImmSh;
        case (opcode)
          OpRType:                        state_d = is_rtype_funct(funct) ? StRExec : StIllegal;
          OpLw, OpSw:                     state_d = StMemAddr;
          OpBeq:                          state_d = StBranch;
          OpJ:                            state_d = StJump;
          OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
          default:                        state_d = StIllegal;
        endcase
      end
      StRExec: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBRt;
        alu_cls       = AluClsFunct;
        state_d       = StRWb;
      end
      StRWb: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StIExec: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBImm;
        ctl.ext_zero  = (opcode == OpAndi) || (opcode == OpOri);
        alu_cls       = AluClsImm;
        state_d       = StIWb;
      end
      StIWb: begin
        ctl.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StMemAddr: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SrcBImm;
        state_d       = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        ctl.mem_read    = 1'b1;
        ctl.i_or_d      = 1'b1;
        ctl.mem_timeout = timeout;
        if (mem_ready)    state_d = StLwWb;
        else if (timeout) state_d = StFetch;
      end
      StLwWb: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        retire         = 1'b1;
        state_d        = StFetch;
      end
      StMemWr: begin
        ctl.mem_write   = 1'b1;
        ctl.i_or_d      = 1'b1;
        ctl.mem_timeout = timeout;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end else if (timeout) begin
          state_d = StFetch;
        end
      end
      StBranch: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SrcBRt;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PcSrcAluOut;
        alu_cls           = AluClsSub;
        retire            = 1'b1;
        state_d           = StFetch;
      end
      StJump: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PcSrcJump;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StIllegal: begin
        ctl.illegal = 1'b1;
        state_d     = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      retired_q <= '0;
      illegal_q <= '0;
    end else begin
      state_q <= state_d;
      // Timeout in FETCH keeps the state, so it must clear the counter explicitly.
      if ((state_d != state_q) || timeout || mem_ready) begin
        wait_q <= '0;
      end else if (wait_state && (wait_q != '1)) begin
        wait_q <= wait_q + WaitW'(1);
      end
      if (retire)                 retired_q <= retired_q + CNT_WIDTH'(1);
      if (state_q == StIllegal)   illegal_q <= illegal_q + CNT_WIDTH'(1);
    end
  end

  // Reset squashes every control strobe, including a write pending this cycle.
  assign ctl_out = reset ? '0 : ctl;
  assign alu_op  = reset ? 4'b0000 : alu_op_raw;

  assign alu_src_a     = ctl_out.alu_src_a;
  assign alu_src_b     = ctl_out.alu_src_b;
  assign ext_zero      = ctl_out.ext_zero;
  assign pc_write      = ctl_out.pc_write;
  assign pc_write_cond = ctl_out.pc_write_cond;
  assign pc_source     = ctl_out.pc_source;
  assign i_or_d        = ctl_out.i_or_d;
  assign mem_read      = ctl_out.mem_read;
  assign mem_write     = ctl_out.mem_write;
  assign ir_write      = ctl_out.ir_write;
  assign reg_dst       = ctl_out.reg_dst;
  assign reg_write     = ctl_out.reg_write;
  assign mem_to_reg    = ctl_out.mem_to_reg;
  assign illegal       = ctl_out.illegal;
  assign mem_timeout   = ctl_out.mem_timeout;
  assign retired       = retired_q;
  assign illegal_count = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control (TIMEOUT_CYCLES=4). Inputs change
// at the falling edge; outputs are sampled 1 time unit later.
module tb_mips_multicycle_control;

  logic        clock, reset, zero, mem_ready;
  logic [5:0]  opcode, funct;
  logic [3:0]  alu_op;
  logic        alu_src_a, ext_zero, pc_write, pc_write_cond, i_or_d;
  logic [1:0]  alu_src_b, pc_source;
  logic        mem_read, mem_write, ir_write, reg_dst, reg_write, mem_to_reg;
  logic        illegal, mem_timeout;
  logic [31:0] retired, illegal_count;

  int n_cmp = 0;
  int n_err = 0;

  mips_multicycle_control #(
    .TIMEOUT_CYCLES (4),
    .CNT_WIDTH      (32)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .ext_zero      (ext_zero),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .illegal       (illegal),
    .mem_timeout   (mem_timeout),
    .retired       (retired),
    .illegal_count (illegal_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Field order: alu_op[20:17] src_a[16] src_b[15:14] ext_zero[13] pc_write[12]
  // pc_write_cond[11] pc_source[10:9] i_or_d[8] mem_read[7] mem_write[6]
  // ir_write[5] reg_dst[4] reg_write[3] mem_to_reg[2] illegal[1] mem_timeout[0]
  logic [20:0] ctl_obs;
  assign ctl_obs = {alu_op, alu_src_a, alu_src_b, ext_zero, pc_write, pc_write_cond,
                    pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    reg_write, mem_to_reg, illegal, mem_timeout};

  localparam logic [20:0] MaskAll  = 21'h1FFFFF;
  localparam logic [20:0] MaskNoOp = 21'h01FFFF;  // ALU op irrelevant in this state

  //                                  op      a     b     ez    pw    pwc   ps     iod   mr    mw    irw   rd    rw    m2r   ill   to
  localparam logic [20:0] CtlZero   = 21'h0;
  localparam logic [20:0] FetchGo   = {4'h2, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] FetchWait = {4'h2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] FetchTo   = {4'h2, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [20:0] Decode    = {4'h2, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] RExecAdd  = {4'h2, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] RWb       = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] IExecOri  = {4'h1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] IExecSlti = {4'h7, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] IWb       = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] MemAddr   = {4'h2, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] MemRd     = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] LwWb      = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [20:0] MemWr     = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] Branch    = {4'h6, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] Jump      = {4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [20:0] Illegal   = {4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic [20:0] exp, input logic [20:0] mask);
    n_cmp++;
    assert ((ctl_obs & mask) === (exp & mask)) else begin
      n_err++;
      $error("FAIL %s: observed %06h expected %06h (mask %06h)", tag, ctl_obs, exp, mask);
    end
  endtask

  // Advance to the next cycle, apply mem_ready, let outputs settle.
  task automatic cyc(input logic rdy);
    @(negedge clock);
    mem_ready = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clock); #1;
    chk_ctl("reset_outputs_zero", CtlZero, MaskAll);
    @(negedge clock); reset = 1'b0; #1;
    chk("reset_retired", retired, 32'd0);
    chk("reset_illegal_count", illegal_count, 32'd0);
    chk_ctl("reset_fetch_wait", FetchWait, MaskAll);

    // add
    opcode = 6'h00; funct = 6'h20;
    cyc(1'b1); chk_ctl("add_fetch", FetchGo, MaskAll);
    cyc(1'b0); chk_ctl("add_decode", Decode, MaskAll);
    cyc(1'b0); chk_ctl("add_rexec", RExecAdd, MaskAll);
    cyc(1'b0); chk_ctl("add_rwb", RWb, MaskNoOp);

    // lw with two not-ready cycles in MEM_RD
    opcode = 6'h23;
    cyc(1'b1); chk_ctl("lw_fetch", FetchGo, MaskAll); chk("retired_after_add", retired, 32'd1);
    cyc(1'b0); chk_ctl("lw_decode", Decode, MaskAll);
    cyc(1'b0); chk_ctl("lw_memaddr", MemAddr, MaskAll);
    cyc(1'b0); chk_ctl("lw_memrd_1", MemRd, MaskNoOp);
    cyc(1'b0); chk_ctl("lw_memrd_2", MemRd, MaskNoOp);
    cyc(1'b1); chk_ctl("lw_memrd_3", MemRd, MaskNoOp);
    cyc(1'b0); chk_ctl("lw_wb", LwWb, MaskNoOp);

    // beq taken then not taken: control identical either way
    opcode = 6'h04; zero = 1'b1;
    cyc(1'b1); chk("retired_after_lw", retired, 32'd2);
    cyc(1'b0); chk_ctl("beq1_decode", Decode, MaskAll);
    cyc(1'b0); chk_ctl("beq1_branch", Branch, MaskAll);
    zero = 1'b0;
    cyc(1'b1); chk("retired_after_beq1", retired, 32'd3);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("beq0_branch", Branch, MaskAll);

    // ori, slti
    opcode = 6'h0D;
    cyc(1'b1); chk("retired_after_beq0", retired, 32'd4);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("ori_iexec", IExecOri, MaskAll);
    cyc(1'b0); chk_ctl("ori_iwb", IWb, MaskNoOp);
    opcode = 6'h0A;
    cyc(1'b1); chk("retired_after_ori", retired, 32'd5);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("slti_iexec", IExecSlti, MaskAll);
    cyc(1'b0); chk_ctl("slti_iwb", IWb, MaskNoOp);

    // j, then sw completing immediately
    opcode = 6'h02;
    cyc(1'b1); chk("retired_after_slti", retired, 32'd6);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("j_jump", Jump, MaskNoOp);
    opcode = 6'h2B;
    cyc(1'b1); chk("retired_after_j", retired, 32'd7);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("sw_memaddr", MemAddr, MaskAll);
    cyc(1'b1); chk_ctl("sw_memwr", MemWr, MaskNoOp);

    // illegal opcode, then illegal R-type funct
    opcode = 6'h3F;
    cyc(1'b1); chk("retired_after_sw", retired, 32'd8);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("ill_op_pulse", Illegal, MaskNoOp);
    opcode = 6'h00; funct = 6'h00;
    cyc(1'b1); chk_ctl("ill_op_pulse_gone", FetchGo, MaskAll);
    chk("illegal_count_1", illegal_count, 32'd1);
    chk("retired_after_ill_op", retired, 32'd8);
    cyc(1'b0); chk_ctl("ill_fn_decode", Decode, MaskAll);
    cyc(1'b0); chk_ctl("ill_fn_pulse", Illegal, MaskNoOp);

    // FETCH timeout: four waiting cycles, abort on the fifth
    cyc(1'b0); chk("illegal_count_2", illegal_count, 32'd2);
    chk("retired_after_ill_fn", retired, 32'd8);
    chk_ctl("to_wait_1", FetchWait, MaskAll);
    for (int i = 2; i <= 4; i++) begin
      cyc(1'b0); chk_ctl($sformatf("to_wait_%0d", i), FetchWait, MaskAll);
    end
    cyc(1'b0); chk_ctl("to_fire", FetchTo, MaskAll);
    cyc(1'b0); chk_ctl("to_restart", FetchWait, MaskAll);
    chk("retired_after_timeout", retired, 32'd8);

    // ready on the would-be timeout cycle completes normally
    opcode = 6'h2B;
    for (int i = 0; i < 3; i++) cyc(1'b0);
    cyc(1'b1); chk_ctl("ready_beats_timeout", FetchGo, MaskAll);
    cyc(1'b0); chk_ctl("sw2_decode", Decode, MaskAll);
    cyc(1'b0);
    cyc(1'b0); chk_ctl("sw2_memwr_wait", MemWr, MaskNoOp);

    // reset during MEM_WR squashes the write
    @(negedge clock); reset = 1'b1; #1;
    chk_ctl("reset_mid_memwr", CtlZero, MaskAll);
    @(negedge clock); reset = 1'b0; #1;
    chk_ctl("after_reset_fetch", FetchWait, MaskAll);
    chk("after_reset_retired", retired, 32'd0);
    chk("after_reset_illegal_count", illegal_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Moore FSM controller for the multicycle MIPS datapath.
- Decodes the instruction register's opcode/funct and sequences fetch/decode/execute/memory/writeback.
- Drives the 4-bit ALU operation select and all datapath enables.
- Consumes the ALU zero flag and a memory ready handshake; counts retired and illegal instructions.

Parameters:
- TIMEOUT_CYCLES, 16: maximum wait cycles on mem_ready before abort. 0 disables the timeout.
- CNT_WIDTH, 32: width of the retired and illegal counters.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; stable from the end of FETCH
- funct  in  6  IR[5:0]
- zero  in  1  ALU Z flag
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=immediate, 11=immediate<<2
- ext_zero  out  1  1=zero-extend immediate, 0=sign-extend
- pc_write, pc_write_cond  out  1 each  unconditional / zero-qualified PC write
- pc_source  out  2  00=ALU, 01=ALUOut, 10=jump target
- i_or_d, mem_read, mem_write, ir_write  out  1 each  memory controls
- reg_dst, reg_write, mem_to_reg  out  1 each  register-file controls
- illegal  out  1  one-cycle pulse on an unsupported opcode/funct
- mem_timeout  out  1  one-cycle pulse on a handshake abort
- retired  out  CNT_WIDTH  completed-instruction count, wraps
- illegal_count  out  CNT_WIDTH  illegal-instruction count, wraps

Behaviour:
- Reset:
  - On the clock edge with reset=1: state=FETCH; retired, illegal_count and the wait counter go to 0.
  - While reset=1 all control outputs are forced to 0.
- Outputs are a pure decode of the state register; no input-to-output combinational path except FETCH/MEM_RD/MEM_WR gating by mem_ready (below).
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0010, pc_source=00.
  - ir_write and pc_write assert only in the cycle mem_ready=1; the FSM then goes to DECODE. Otherwise it holds.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=0010 (branch target), then dispatch on opcode:
  - 0x00 -> R_EXEC if funct is in {0x20, 0x22, 0x24, 0x25, 0x27, 0x2A}; otherwise ILLEGAL.
  - 0x23 / 0x2B -> MEM_ADDR.
  - 0x04 -> BRANCH.
  - 0x02 -> JUMP.
  - 0x08 / 0x0C / 0x0D / 0x0A -> I_EXEC.
  - Anything else -> ILLEGAL.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_op from funct: 20 ADD, 22 SUB, 24 AND, 25 OR, 27 NOR, 2A SLT.
  - Next state R_WB.
- R_WB: reg_dst=1, reg_write=1, mem_to_reg=0 -> FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=10.
  - addi ADD (ext_zero=0); andi AND (ext_zero=1); ori OR (ext_zero=1); slti SLT (ext_zero=0).
  - Next state I_WB.
- I_WB: reg_dst=0, reg_write=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=0010 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1; on mem_ready -> LW_WB.
- LW_WB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1; on mem_ready -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=0110, pc_write_cond=1, pc_source=01 -> FETCH. The datapath gates the PC write with zero.
- JUMP: pc_write=1, pc_source=10 -> FETCH.
- ILLEGAL: illegal=1 for one cycle; illegal_count+1; retired unchanged -> FETCH.
- retired increments on every transition into FETCH from R_WB, I_WB, LW_WB, MEM_WR, BRANCH or JUMP.
- Wait counter:
  - Counts cycles spent in FETCH/MEM_RD/MEM_WR with mem_ready=0; clears on state change.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: mem_timeout pulses, no ir_write/pc_write/reg_write occurs, next state FETCH. The PC is not advanced; retired is unchanged.
- mem_ready arriving on the same cycle the timeout would fire: the access completes normally; there is no timeout.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Reset asserted mid-instruction: any pending write is suppressed in that cycle (outputs forced 0); restart at FETCH.
- Counters wrap from 2^CNT_WIDTH-1 to 0 without a flag.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALU OP codes (0000, 0001, 0010, 0110, 0111, 0100, 1100), including XNOR reserved/unused;
  - state encoding;
  - alu_src_b and pc_source codes.
- Sub-module mips_alu_decoder: combinational; inputs a class (ADD/SUB/FUNCT/IMM) plus opcode/funct; outputs alu_op.

Test Plan:
- Reset, then R-type add (opcode 0x00, funct 0x20) with mem_ready=1 -> states FETCH, DECODE, R_EXEC(alu_op=0010), R_WB(reg_write=1, reg_dst=1); retired=1 after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in MEM_RD -> mem_read held 3 cycles; LW_WB mem_to_reg=1; total 7 cycles; retired+1.
- beq (0x04) with zero=1 and zero=0 -> BRANCH: alu_op=0110, pc_write_cond=1, pc_source=01; 3 cycles each.
- ori (0x0D) -> I_EXEC: alu_op=0001, ext_zero=1, alu_src_b=10; slti (0x0A) -> alu_op=0111, ext_zero=0.
- opcode 0x3F, then R-type funct 0x00 -> illegal pulses once each; illegal_count=2; retired unchanged.
- TIMEOUT_CYCLES=4 with mem_ready stuck 0 in FETCH -> mem_timeout on the 5th FETCH cycle, no ir_write; reset asserted during MEM_WR -> mem_write=0 that cycle, state FETCH, counters 0.
